// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared state encoding, opcode/op constants, ALUop and vsel codes
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_GETA,
    ST_GETB,
    ST_EXEC,
    ST_WRREG,
    ST_WRIMM
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL,
    CL_MOV_IMM,
    CL_MOV_REG,
    CL_ADD,
    CL_CMP,
    CL_AND,
    CL_MVN
  } instr_class_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b10;

  function automatic instr_class_t classify(input logic [2:0] opcode, input logic [1:0] op);
    instr_class_t cls;
    cls = CL_ILLEGAL;
    if (opcode == OPC_MOV && op == OP_MOV_IMM) cls = CL_MOV_IMM;
    else if (opcode == OPC_MOV && op == OP_MOV_REG) cls = CL_MOV_REG;
    else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  cls = CL_ADD;
        OP_CMP:  cls = CL_CMP;
        OP_AND:  cls = CL_AND;
        default: cls = CL_MVN;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// rtl/datapath_ctrl_instr_dec.sv - IR field split, sign extension and instruction classification
module instr_dec
  import datapath_ctrl_pkg::*;
(
  input  logic [15:0]  ir_i,
  output logic [2:0]   rn_o,
  output logic [2:0]   rd_o,
  output logic [1:0]   sh_o,
  output logic [2:0]   rm_o,
  output logic [15:0]  sximm5_o,
  output logic [15:0]  sximm8_o,
  output instr_class_t cls_o
);

  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
  assign cls_o    = classify(ir_i[15:13], ir_i[12:11]);

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - instruction register and Moore sequencer driving the 16-bit datapath strobes
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        illegal,
  output logic [1:0]  vsel,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  state_t       state_q, state_d;
  logic [15:0]  ir_q, ir_d;
  logic         illegal_q, illegal_d;
  logic [2:0]   rn, rd, rm;
  logic [1:0]   sh;
  instr_class_t cls;

  instr_dec u_dec (
    .ir_i     (ir_q),
    .rn_o     (rn),
    .rd_o     (rd),
    .sh_o     (sh),
    .rm_o     (rm),
    .sximm5_o (sximm5),
    .sximm8_o (sximm8),
    .cls_o    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_WAIT;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // IR only loads while idle, so an s in the same cycle executes the new word
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_WAIT: begin
        if (load) ir_d = in;
        if (s)    state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (cls)
          CL_MOV_IMM:                 state_d = ST_WRIMM;
          CL_MOV_REG, CL_MVN:         state_d = ST_GETB;
          CL_ADD, CL_CMP, CL_AND:     state_d = ST_GETA;
          default: begin
            state_d   = ST_WAIT;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_GETA:  state_d = ST_GETB;
      ST_GETB:  state_d = ST_EXEC;
      ST_EXEC:  state_d = (cls == CL_CMP) ? ST_WAIT : ST_WRREG;
      default:  state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    w        = (state_q == ST_WAIT);
    illegal  = illegal_q;
    vsel     = VSEL_C;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = ALU_ADD;
    shift    = 2'b00;
    case (state_q)
      ST_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      ST_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      ST_EXEC: begin
        shift = sh;
        asel  = (cls == CL_MOV_REG) || (cls == CL_MVN);
        loadc = (cls != CL_CMP);
        loads = (cls == CL_CMP);
        case (cls)
          CL_CMP:  ALUop = ALU_CMP;
          CL_AND:  ALUop = ALU_AND;
          CL_MVN:  ALUop = ALU_MVN;
          default: ALUop = ALU_ADD;
        endcase
      end
      ST_WRREG: begin
        vsel     = VSEL_C;
        writenum = rd;
        write    = 1'b1;
      end
      ST_WRIMM: begin
        vsel     = VSEL_SXIMM8;
        writenum = rn;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - scoreboard bench for datapath_ctrl with directed instruction vectors
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, ALUop, shift;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm5, sximm8;

  int n_chk  = 0;
  int n_fail = 0;
  logic exp_ill = 1'b0;
  logic [19:0] exp_q[$];

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_WR   = 5'b10000;
  localparam logic [4:0] S_LA   = 5'b01000;
  localparam logic [4:0] S_LB   = 5'b00100;
  localparam logic [4:0] S_LC   = 5'b00010;
  localparam logic [4:0] S_LS   = 5'b00001;

  datapath_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .illegal(illegal), .vsel(vsel), .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift),
    .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // record: {illegal, write,loada,loadb,loadc,loads, readnum, writenum, vsel, asel, bsel, ALUop, shift}
  task automatic push(input logic [4:0] st, input logic [2:0] rn, input logic [2:0] wn,
                      input logic [1:0] vs, input logic as, input logic bs,
                      input logic [1:0] alu, input logic [1:0] sh);
    exp_q.push_back({exp_ill, st, rn, wn, vs, as, bs, alu, sh});
  endtask

  // monitor: every non-idle cycle is one expected output record
  always @(negedge clk) begin
    if (w === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_busy_cycle", 32'd1, 32'd0);
      end else begin
        check("cycle_outputs",
              {12'd0, illegal, write, loada, loadb, loadc, loads, readnum, writenum,
               vsel, asel, bsel, ALUop, shift},
              {12'd0, exp_q.pop_front()});
      end
    end
  end

  // inj_kind 1: load 16'hFFFF for one cycle at step inj_n; inj_kind 2: reset for one cycle
  task automatic run(input string name, input logic [15:0] instr, input bit same,
                     input int lat, input int inj_n, input int inj_kind);
    int n;
    in = instr;
    load = 1'b1;
    if (!same) begin
      @(posedge clk); #1;
      load = 1'b0;
    end
    s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0;
    load = 1'b0;
    n = 1;
    while (w !== 1'b1 && n < 30) begin
      if (n == inj_n) begin
        if (inj_kind == 1) begin
          load = 1'b1;
          in = 16'hFFFF;
        end else begin
          reset = 1'b1;
        end
      end
      @(posedge clk); #1;
      n++;
      load = 1'b0;
      reset = 1'b0;
    end
    check({name, "_latency"}, n, lat);
    check({name, "_records_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_state", {w, illegal, write, loada, loadb, loadc, loads}, 7'b1000000);
    reset = 1'b0;
    @(posedge clk); #1;

    // MOV R1,#-10
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_WR,   0, 1, 2'b10, 0, 0, 2'b00, 2'b00);
    run("mov_imm", 16'hD1F6, 0, 3, -1, 0);
    check("mov_imm_sximm8", sximm8, 16'hFFF6);

    // ADD R2,R1,R0 LSL1
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LA,   1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LB,   0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LC,   0, 0, 2'b00, 0, 0, 2'b00, 2'b01);
    push(S_WR,   0, 2, 2'b00, 0, 0, 2'b00, 2'b00);
    run("add", 16'hA148, 0, 6, -1, 0);
    check("add_sximm5", sximm5, 16'h0008);

    // CMP R1,R0
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LA,   1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LB,   0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LS,   0, 0, 2'b00, 0, 0, 2'b01, 2'b00);
    run("cmp", 16'hA900, 0, 5, -1, 0);

    // AND R3,R4,R5 LSR
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LA,   4, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LB,   5, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LC,   0, 0, 2'b00, 0, 0, 2'b10, 2'b10);
    push(S_WR,   0, 3, 2'b00, 0, 0, 2'b00, 2'b00);
    run("and", 16'hB475, 0, 6, -1, 0);

    // MOV R5,R2 LSL1
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LB,   2, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LC,   0, 0, 2'b00, 1, 0, 2'b00, 2'b01);
    push(S_WR,   0, 5, 2'b00, 0, 0, 2'b00, 2'b00);
    run("mov_reg", 16'hC0AA, 0, 5, -1, 0);

    // MVN R6,R7 ASR, loaded in the same cycle as s
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LB,   7, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LC,   0, 0, 2'b00, 1, 0, 2'b11, 2'b11);
    push(S_WR,   0, 6, 2'b00, 0, 0, 2'b00, 2'b00);
    run("mvn_load_with_s", 16'hB8DF, 1, 5, -1, 0);
    check("mvn_sximm5", sximm5, 16'hFFFF);

    // ADD with load of FFFF during EXEC: IR must hold
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LA,   1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LB,   0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LC,   0, 0, 2'b00, 0, 0, 2'b00, 2'b01);
    push(S_WR,   0, 2, 2'b00, 0, 0, 2'b00, 2'b00);
    run("add_load_in_exec", 16'hA148, 0, 6, 4, 1);
    check("ir_held_sximm8", sximm8, 16'h0048);

    // ADD with reset during GETB: no WRREG write
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LA,   1, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_LB,   0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    run("add_reset_in_getb", 16'hA148, 0, 4, 3, 2);
    check("post_reset_state", {w, illegal, write, loada, loadb, loadc, loads}, 7'b1000000);
    check("post_reset_ir", sximm8, 16'h0000);

    // illegal opcode 111
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    run("illegal_opc", 16'hE000, 0, 2, -1, 0);
    check("illegal_set", illegal, 1'b1);
    exp_ill = 1'b1;

    // illegal pair 110/11 while already sticky
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    run("illegal_mov_op", 16'hD800, 0, 2, -1, 0);

    // legal MOV R7,#5 still runs with illegal held
    push(S_NONE, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    push(S_WR,   0, 7, 2'b10, 0, 0, 2'b00, 2'b00);
    run("mov_imm_after_illegal", 16'hD705, 0, 3, -1, 0);
    check("mov_imm2_sximm8", sximm8, 16'h0005);
    check("illegal_sticky", illegal, 1'b1);

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ill = 1'b0;
    check("illegal_cleared", {w, illegal}, 2'b10);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed by the 16-bit datapath.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high; sampled on posedge clk.
REQ-004 s  in  1  start; begins execution of the held instruction.
REQ-005 load  in  1  instruction-register load strobe.
REQ-006 in  in  16  instruction word.
REQ-007 w  out  1  idle/ready; 1 only in state WAIT.
REQ-008 illegal  out  1  sticky flag set by an undefined opcode/op pair.
REQ-009 vsel  out  2  datapath write-back select: 00 = C, 01 = PC, 10 = sximm8, 11 = mdata.
REQ-010 readnum, writenum  out  3 each  register-file read and write addresses.
REQ-011 write, loada, loadb, loadc, loads  out  1 each  datapath strobes.
REQ-012 asel, bsel  out  1 each  asel=1 forces A to 0; bsel=1 selects sximm5.
REQ-013 ALUop, shift  out  2 each  ALU operation and shifter code.
REQ-014 sximm5, sximm8  out  16 each  sign-extended IR[4:0] and IR[7:0].

Function
REQ-015 IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-016 IR captures `in` on the clock edge when load=1 and state=WAIT; load is ignored in all other states.
REQ-017 States: WAIT, DECODE, GETA, GETB, EXEC, WRREG, WRIMM; one transition per clock.
REQ-018 WAIT -> DECODE on s=1; otherwise stay in WAIT.
REQ-019 If load=1 and s=1 in the same WAIT cycle, the new IR value is the instruction executed.
REQ-020 DECODE routing:
- 110/10 (MOV imm) -> WRIMM.
- 110/00 (MOV reg) and 101/11 (MVN) -> GETB.
- 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GETA.
- Any other pair -> WAIT with illegal set.
REQ-021 GETA: readnum=Rn, loada=1; -> GETB.
REQ-022 GETB: readnum=Rm, loadb=1; -> EXEC.
REQ-023 EXEC: shift=sh, bsel=0; ALUop = 00 ADD, 01 CMP, 10 AND, 11 MVN, 00 MOV-reg.
REQ-024 EXEC: asel=1 for MOV-reg and MVN, else 0.
REQ-025 EXEC: loadc=1 except for CMP; loads=1 only for CMP.
REQ-026 EXEC: CMP -> WAIT; all other instructions -> WRREG.
REQ-027 WRREG: vsel=00, writenum=Rd, write=1; -> WAIT.
REQ-028 WRIMM: vsel=10, writenum=Rn, write=1; -> WAIT.
REQ-029 Outputs are Moore, decoded from registered state and IR only; no combinational path from s, load or in to any strobe.
REQ-030 Strobes not named for a state are 0; readnum, writenum, ALUop, shift, vsel, asel and bsel are 0 when unused.
REQ-031 Latency from the s-sampling edge back to w=1: MOV imm 3 cycles, MOV-reg/MVN 5, CMP 5, ADD/AND 6.
REQ-032 An illegal instruction returns to WAIT 2 cycles after the s-sampling edge.
REQ-033 illegal clears only on reset; a later legal instruction executes normally while illegal stays 1.
REQ-034 At most one of write, loada, loadb, loadc, loads is 1 in any cycle.

Reset
REQ-035 reset=1 at any edge forces state=WAIT, IR=0 and illegal=0, regardless of the current state.
REQ-036 After reset, w=1 and all strobes are 0; a write in progress when reset asserts is not performed.
REQ-037 reset has priority over s and load in the same cycle.

Structure
REQ-038 The shared package datapath_ctrl_pkg holds the state encoding, opcode/op constants, ALUop codes and vsel codes.
REQ-039 Sign extension and field decode live in one sub-module, instr_dec (IR in; fields, sximm5, sximm8 and the instruction class out).

Verification
REQ-040 MOV imm: load in=16'hD1F6 (MOV R1,#-10), then s -> WRIMM has writenum=1, vsel=10, sximm8=16'hFFF6; w=1 three cycles after s.
REQ-041 ADD R2,R1,R0 LSL1 (16'hA148): GETA readnum=1, GETB readnum=0, EXEC shift=01 ALUop=00, WRREG writenum=2; w=1 after 6 cycles.
REQ-042 CMP R1,R0 (16'hA900): loads pulses exactly once, write is never 1, ALUop=01; w=1 after 5 cycles.
REQ-043 Illegal opcode 16'hE000: illegal=1 and w=1 two cycles after s, with no strobes asserted.
REQ-044 Reset asserted in GETB of an ADD -> next cycle state=WAIT, w=1, and no WRREG write occurs.
REQ-045 load=1 with in=16'hFFFF during an ADD's EXEC -> IR is unchanged and the ADD completes with Rd from the original IR.
